// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit carry chain reused NCHUNK times,
// with start/busy/done handshake and registered sum, carry-out and overflow.
module chunked_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, psum_reg, psum_next, sum_reg;
  logic             carry_reg, cout_reg, ovf_reg;
  logic [IDX_W-1:0] idx_reg;

  logic             accept, last_chunk, msb_carry_in;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;

  assign accept     = start && (state_reg == IDLE || state_reg == DONE);
  assign last_chunk = (idx_reg == IDX_W'(NCHUNK - 1));

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_chunk = a_reg[i*CHUNK +: CHUNK];
        b_chunk = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_reg);

  // The carry into a sum bit is recoverable as a ^ b ^ s of that bit.
  assign msb_carry_in = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ chunk_sum[CHUNK-1];

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_psum
      assign psum_next[gi*CHUNK +: CHUNK] =
        (idx_reg == IDX_W'(gi)) ? chunk_sum[CHUNK-1:0] : psum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      psum_reg  <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub ? ~b : b;
      carry_reg <= cin ^ sub;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      psum_reg  <= psum_next;
      carry_reg <= chunk_sum[CHUNK];
      idx_reg   <= idx_reg + IDX_W'(1);
      if (last_chunk) begin
        sum_reg  <= psum_next;
        cout_reg <= chunk_sum[CHUNK];
        ovf_reg  <= msb_carry_in ^ chunk_sum[CHUNK];
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder at WIDTH=8 with CHUNK of 4 (main), 1 and 8.
module tb_chunked_seq_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0, sub = 1'b0;

  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent integer reference: unsigned range for carry, signed range for overflow.
  function automatic logic [9:0] model(input logic [7:0] va, input logic [7:0] vb,
                                       input logic vcin, input logic vsub);
    int ua = int'(va);
    int ub = int'(vb);
    int sa = int'($signed(va));
    int sb = int'($signed(vb));
    int r, sr;
    logic co;
    if (!vsub) begin
      r  = ua + ub + int'(vcin);
      sr = sa + sb + int'(vcin);
      co = (r > 255);
    end else begin
      r  = ua - ub - int'(vcin);
      sr = sa - sb - int'(vcin);
      co = (r >= 0);
    end
    return {r[7:0], co, (sr > 127 || sr < -128)};
  endfunction

  // Launch one operation on all three instances and compare each at its done pulse.
  task automatic run_all(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vcin, input logic vsub, input logic [9:0] exp);
    logic [9:0] r4, r1, r8;
    logic [2:0] got;
    r4 = '0; r1 = '0; r8 = '0; got = '0;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    for (int c = 0; c < 12 && got != 3'b111; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done4 && !got[0]) begin r4 = {sum4, cout4, ovf4}; got[0] = 1'b1; end
      if (done1 && !got[1]) begin r1 = {sum1, cout1, ovf1}; got[1] = 1'b1; end
      if (done8 && !got[2]) begin r8 = {sum8, cout8, ovf8}; got[2] = 1'b1; end
    end
    check({tag, " done_seen"}, 16'(got), 16'(3'b111));
    check({tag, " c4"}, 16'(r4), 16'(exp));
    check({tag, " c1"}, 16'(r1), 16'(exp));
    check({tag, " c8"}, 16'(r8), 16'(exp));
    $display("op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
             tag, va, vb, vcin, vsub, r4[9:2], r4[1], r4[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[7]  = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[8]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[9]  = '{8'h3C, 8'hA5, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b0};
    tbl[10] = '{8'h12, 8'h12, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset c4", {5'b0, busy4, done4, sum4, cout4, ovf4}, 16'h0);
    check("reset c1", {5'b0, busy1, done1, sum1, cout1, ovf1}, 16'h0);
    check("reset c8", {5'b0, busy8, done8, sum8, cout8, ovf8}, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_all($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
              {tbl[i].sum, tbl[i].cout, tbl[i].ovf});

    // Latency, busy window, operand changes after acceptance, result held during RUN
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    check("lat e1 busy/done", {busy4, done4}, 16'b10);
    check("lat e1 sum held", 16'(sum4), 16'(tbl[11].sum));
    @(negedge clk);
    start = 1'b1;
    check("lat e2 busy/done", {busy4, done4}, 16'b10);
    check("lat e2 sum held", 16'(sum4), 16'(tbl[11].sum));
    @(negedge clk);
    start = 1'b0;
    check("lat e3 busy/done", {busy4, done4}, 16'b01);
    check("lat e3 result", {sum4, cout4, ovf4}, {8'h10, 1'b0, 1'b0});
    @(negedge clk);
    check("lat e4 busy/done", {busy4, done4}, 16'b00);
    $display("op seqA latency a=0f b=01 -> sum=%h", sum4);

    // start held high: back-to-back every 3 cycles, starts during RUN ignored
    @(negedge clk);
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      check($sformatf("b2b j%0d busy/done", j), {busy4, done4},
            (j % 3 == 2) ? 16'b01 : 16'b10);
      if (j % 3 == 2) begin
        check($sformatf("b2b j%0d sum", j), 16'(sum4), 16'(j - 2));
        $display("op b2b%0d a=%h -> sum=%h", j, 8'(j - 2), sum4);
      end
      a = 8'(j + 1);
    end
    start = 1'b0;

    // Async reset mid-RUN clears outputs immediately and suppresses done
    @(negedge clk);
    a = 8'h0F; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid c4", {5'b0, busy4, done4, sum4, cout4, ovf4}, 16'h0);
    check("rst mid c1", {5'b0, busy1, done1, sum1, cout1, ovf1}, 16'h0);
    check("rst mid c8", {5'b0, busy8, done8, sum8, cout8, ovf8}, 16'h0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("rst nodone j%0d", j), {busy4, done4, busy1, done1, busy8, done8}, 16'h0);
    end
    $display("op reset mid-run -> outputs cleared");
    run_all("post_rst", 8'h0F, 8'h01, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0});

    // Sampled sweep against the integer reference model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_all($sformatf("rnd%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
